// File: rtl/prf_pkg.sv
// prf_pkg: shared defaults, tag/data types and sweep FSM states for the
// multiport physical register file.
package prf_pkg;

  localparam int PRF_DATA_WIDTH = 32;
  localparam int PRF_NUM_REGS   = 64;
  localparam int PRF_ADDR_WIDTH = $clog2(PRF_NUM_REGS);
  localparam int PRF_NUM_RD     = 6;
  localparam int PRF_NUM_WR     = 2;
  localparam int PRF_NUM_ALLOC  = 2;

  typedef logic [PRF_ADDR_WIDTH-1:0] prf_tag_t;
  typedef logic [PRF_DATA_WIDTH-1:0] prf_data_t;

  // INIT: zeroing sweep in progress; RUN: normal operation until next reset.
  typedef enum logic {
    PRF_INIT = 1'b0,
    PRF_RUN  = 1'b1
  } prf_state_e;

endpackage

// File: rtl/prf_read_port.sv
// prf_read_port: one asynchronous read lane of the physical register file.
// Selects the addressed register and its ready bit, forces tag 0 and the
// INIT sweep to read as zero/ready, and (when PRF_BYPASS_EN is defined)
// forwards same-cycle CDB write data ahead of the array.
module prf_read_port
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH = PRF_DATA_WIDTH,
  parameter int NUM_REGS   = PRF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_WR     = PRF_NUM_WR
) (
  input  logic                           i_run,
  input  logic [ADDR_WIDTH-1:0]          i_raddr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_regs,
  input  logic [NUM_REGS-1:0]            i_ready,
`ifdef PRF_BYPASS_EN
  input  logic [NUM_WR-1:0]              i_wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   i_waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   i_wdata,
`endif
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic                           o_rready
);

  logic [DATA_WIDTH-1:0] w_entry;
  logic                  w_entry_ready;

  // array mux and ready lookup for the requested tag
  always_comb begin
    w_entry       = i_regs[i_raddr*DATA_WIDTH +: DATA_WIDTH];
    w_entry_ready = i_ready[i_raddr];
  end

  // tag 0 and the INIT sweep read as zero/ready; optional same-cycle forward,
  // later lanes override earlier ones so the highest matching lane wins
  always_comb begin
    o_rdata  = '0;
    o_rready = 1'b1;
    if (i_run && (i_raddr != '0)) begin
      o_rdata  = w_entry;
      o_rready = w_entry_ready;
`ifdef PRF_BYPASS_EN
      for (int l = 0; l < NUM_WR; l++) begin
        if (i_wen[l] && (i_waddr[l*ADDR_WIDTH +: ADDR_WIDTH] == i_raddr)) begin
          o_rdata  = i_wdata[l*DATA_WIDTH +: DATA_WIDTH];
          o_rready = 1'b1;
        end
      end
`endif
    end
  end

`ifndef PRF_BYPASS_EN
  localparam int NUM_WR_UNUSED = NUM_WR;
`endif

endmodule

// File: rtl/multiport_phys_reg_file.sv
// multiport_phys_reg_file: NUM_REGS-entry physical register file with NUM_RD
// combinational read ports, NUM_WR CDB write lanes, NUM_ALLOC rename lanes
// and a per-register ready scoreboard. After reset a sweep FSM writes zero
// into every entry (one per cycle) so the data array needs no reset.
// Optional macro PRF_BYPASS_EN forwards same-cycle write data to readers.
module multiport_phys_reg_file
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH = PRF_DATA_WIDTH,
  parameter int NUM_REGS   = PRF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD     = PRF_NUM_RD,
  parameter int NUM_WR     = PRF_NUM_WR,
  parameter int NUM_ALLOC  = PRF_NUM_ALLOC
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_done,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]  rdata,
  output logic [NUM_RD-1:0]             rready,
  input  logic [NUM_WR-1:0]             wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]  waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]  wdata,
  input  logic [NUM_ALLOC-1:0]          alloc_en,
  input  logic [NUM_ALLOC*ADDR_WIDTH-1:0] alloc_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  prf_state_e                 r_state;
  prf_state_e                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_idx;
  logic                       w_run;

  logic [DATA_WIDTH-1:0]      r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]        r_ready;
  logic [NUM_REGS*DATA_WIDTH-1:0] w_regs_flat;

  logic [ADDR_WIDTH-1:0]      w_waddr [NUM_WR];
  logic [DATA_WIDTH-1:0]      w_wdata [NUM_WR];
  logic [ADDR_WIDTH-1:0]      w_aaddr [NUM_ALLOC];

  // unpack the flat lane buses into per-lane views
  for (genvar gw = 0; gw < NUM_WR; gw++) begin : g_wr_lane
    assign w_waddr[gw] = waddr[gw*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[gw] = wdata[gw*DATA_WIDTH +: DATA_WIDTH];
  end
  for (genvar ga = 0; ga < NUM_ALLOC; ga++) begin : g_al_lane
    assign w_aaddr[ga] = alloc_addr[ga*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // sweep FSM state register and sweep index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PRF_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == PRF_INIT) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // leave INIT on the edge that zeroes the last entry; RUN holds until reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PRF_INIT: if (r_idx == LAST_IDX) w_state_nxt = PRF_RUN;
      PRF_RUN:  w_state_nxt = PRF_RUN;
      default:  w_state_nxt = PRF_INIT;
    endcase
  end

  // FSM outputs: run qualifier for the datapath and the init_done flag
  always_comb begin
    w_run     = (r_state == PRF_RUN);
    init_done = w_run;
  end

  // data array: zero sweep in INIT, CDB writes in RUN (later lane wins)
  always_ff @(posedge clk) begin
    if (r_state == PRF_INIT) begin
      r_regs[r_idx] <= '0;
    end else begin
      for (int l = 0; l < NUM_WR; l++) begin
        if (wen[l] && (w_waddr[l] != '0)) begin
          r_regs[w_waddr[l]] <= w_wdata[l];
        end
      end
    end
  end

  // ready scoreboard: writeback sets, allocation clears; alloc applied last
  // so a same-cycle alloc of a written tag leaves it not-ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= '1;
    end else if (w_run) begin
      for (int l = 0; l < NUM_WR; l++) begin
        if (wen[l] && (w_waddr[l] != '0)) begin
          r_ready[w_waddr[l]] <= 1'b1;
        end
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (alloc_en[a] && (w_aaddr[a] != '0)) begin
          r_ready[w_aaddr[a]] <= 1'b0;
        end
      end
    end
  end

  // flatten the array so each read port sees one packed bus
  for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_flat
    assign w_regs_flat[gr*DATA_WIDTH +: DATA_WIDTH] = r_regs[gr];
  end

  // one read lane per port
  for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_rd
    prf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WR     (NUM_WR)
    ) u_rd (
      .i_run    (w_run),
      .i_raddr  (raddr[gp*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_regs   (w_regs_flat),
      .i_ready  (r_ready),
`ifdef PRF_BYPASS_EN
      .i_wen    (wen),
      .i_waddr  (waddr),
      .i_wdata  (wdata),
`endif
      .o_rdata  (rdata[gp*DATA_WIDTH +: DATA_WIDTH]),
      .o_rready (rready[gp])
    );
  end

  // two CDB lanes must never target the same non-zero tag in one cycle
  always @(posedge clk) begin
    if (w_run) begin
      for (int a = 0; a < NUM_WR; a++) begin
        for (int b = a + 1; b < NUM_WR; b++) begin
          assert (!(wen[a] && wen[b] && (w_waddr[a] == w_waddr[b]) &&
                    (w_waddr[a] != '0)));
        end
      end
    end
  end

endmodule
